tmr_down_counter: RTL and testbench
===================================

TMR_DOWN_COUNTER -- requirements
Module: tmr_down_counter

Interface
REQ-001 SHALL have parameter width, default 8, the bit width of each replica and of q_out.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port load, input, 1 bit: load load_val into all three replicas.
REQ-005 SHALL have port load_val, input, width bits: the load value.
REQ-006 SHALL have port enable, input, 1 bit: decrement request.
REQ-007 SHALL have port clr_fault, input, 1 bit: clears sticky_fault and fault_cnt.
REQ-008 SHALL have port inject_sel, input, 3 bits: one-hot-or-more replica select for fault injection.
REQ-009 SHALL have port inject_mask, input, width bits: XOR mask for fault injection.
REQ-010 SHALL have port q_out, output, width bits: voted count.
REQ-011 SHALL have port zero, output, 1 bit: high when q_out == 0.
REQ-012 SHALL have port done, output, 1 bit, registered: pulse on decrement to zero.
REQ-013 SHALL have port fault_vec, output, 3 bits: bit i high when replica i != voted value (combinational).
REQ-014 SHALL have port uncorrectable, output, 1 bit: high when all three replicas differ pairwise (combinational).
REQ-015 SHALL have port sticky_fault, output, 3 bits, registered: latched fault_vec.
REQ-016 SHALL have port fault_cnt, output, 8 bits, registered: saturating count of faulty cycles.

Function
REQ-017 Voter SHALL select: q_1 if q_1==q_2 or q_1==q_3; else q_2 if q_2==q_3; else the bitwise majority (q_1&q_2)|(q_1&q_3)|(q_2&q_3).
REQ-018 The base value of replica i SHALL be the voted value when fault_vec[i]=1, else its own value; resync occurs every cycle, independent of enable.
REQ-019 Next value of each replica SHALL follow the priority rst > load > enable: rst->0; load->load_val; enable with base != 0 -> base-1; enable with base == 0 -> 0 (saturate, no wrap); otherwise base.
REQ-020 When inject_sel[i]=1 and rst=0, replica i SHALL register (next value XOR inject_mask) in that cycle; injection is visible on fault_vec the following cycle.
REQ-021 done SHALL be 1 in the cycle after an edge where rst=0, load=0, enable=1 and voted value==1, i.e. coincident with q_out first reading 0; otherwise 0.
REQ-022 load together with enable SHALL perform the load only and SHALL NOT assert done; load_val=0 gives zero=1, done=0.
REQ-023 sticky_fault[i] SHALL set when fault_vec[i]=1 and clear on clr_fault; set wins when both occur in the same cycle.
REQ-024 fault_cnt SHALL increment by 1 on each cycle in which fault_vec != 0 or uncorrectable=1, and SHALL saturate at 255; clr_fault forces it to 0 and wins over increment.
REQ-025 q_out, zero, fault_vec and uncorrectable SHALL be combinational from the replica registers; there are no additional pipeline stages.

Reset
REQ-026 On rst, all replicas, q_out, done, sticky_fault and fault_cnt SHALL be 0, and zero SHALL be 1; fault_vec and uncorrectable SHALL read 0 on the following cycle.
REQ-027 rst SHALL override load, enable, clr_fault and injection in the same cycle, including when asserted mid-countdown.

Verification
REQ-028 rst, then load 5, then enable for 7 cycles -> q_out 4,3,2,1,0,0,0; done high only in the cycle q_out first reads 0; zero=1 from then on.
REQ-029 load 0x20, enable=0, inject_sel=010 with mask 0x01 for one cycle -> next cycle q_out=0x20, fault_vec=010, uncorrectable=0; the cycle after, fault_vec=000, sticky_fault=010, fault_cnt=1.
REQ-030 Value 0x10, inject_sel=011 with inject_mask=0x01 then 0x02 (sequential bench steps, same cycle) giving replicas 0x11/0x12/0x10 -> q_out=0x10, uncorrectable=1, fault_vec=011; the next cycle all replicas equal 0x10.
REQ-031 q_out=3, with load=1, load_val=9 and enable=1 together -> q_out=9, done=0.
REQ-032 clr_fault asserted in the same cycle as an active fault -> sticky_fault bit stays set and fault_cnt=0; 300 consecutive faulty cycles -> fault_cnt=255.
REQ-033 rst asserted with q_out=0x40, enable=1 and an injection active -> next cycle q_out=0, zero=1, done=0, sticky_fault=000, fault_cnt=0.

Source files
------------

// File: rtl/tmr_down_counter.sv
// Triple-modular-redundant saturating down counter with majority voting,
// per-cycle replica resynchronisation, fault injection and fault bookkeeping.
module tmr_down_counter #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [width-1:0] load_val,
  input  logic             enable,
  input  logic             clr_fault,
  input  logic [2:0]       inject_sel,
  input  logic [width-1:0] inject_mask,
  output logic [width-1:0] q_out,
  output logic             zero,
  output logic             done,
  output logic [2:0]       fault_vec,
  output logic             uncorrectable,
  output logic [2:0]       sticky_fault,
  output logic [7:0]       fault_cnt
);

  logic [width-1:0] q_1, q_2, q_3;
  logic [width-1:0] base_1, base_2, base_3;
  logic [width-1:0] nxt_1, nxt_2, nxt_3;

  function automatic logic [width-1:0] vote(input logic [width-1:0] a,
                                            input logic [width-1:0] b,
                                            input logic [width-1:0] c);
    if (a == b || a == c) return a;
    else if (b == c)      return b;
    else                  return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [width-1:0] sat_dec(input logic [width-1:0] x);
    return (x == '0) ? '0 : x - width'(1);
  endfunction

  function automatic logic [width-1:0] next_val(input logic [width-1:0] base);
    if (load)        return load_val;
    else if (enable) return sat_dec(base);
    else             return base;
  endfunction

  always_comb begin
    q_out         = vote(q_1, q_2, q_3);
    zero          = (q_out == '0);
    fault_vec     = {q_3 != q_out, q_2 != q_out, q_1 != q_out};
    uncorrectable = (q_1 != q_2) && (q_1 != q_3) && (q_2 != q_3);
    // A replica that disagrees with the vote is repaired before it advances.
    base_1 = fault_vec[0] ? q_out : q_1;
    base_2 = fault_vec[1] ? q_out : q_2;
    base_3 = fault_vec[2] ? q_out : q_3;
    nxt_1  = next_val(base_1) ^ (inject_sel[0] ? inject_mask : '0);
    nxt_2  = next_val(base_2) ^ (inject_sel[1] ? inject_mask : '0);
    nxt_3  = next_val(base_3) ^ (inject_sel[2] ? inject_mask : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_1          <= '0;
      q_2          <= '0;
      q_3          <= '0;
      done         <= 1'b0;
      sticky_fault <= 3'b000;
      fault_cnt    <= 8'd0;
    end else begin
      q_1          <= nxt_1;
      q_2          <= nxt_2;
      q_3          <= nxt_3;
      done         <= !load && enable && (q_out == width'(1));
      // Setting a sticky bit takes precedence over clearing it.
      sticky_fault <= fault_vec | (sticky_fault & {3{~clr_fault}});
      if (clr_fault)
        fault_cnt <= 8'd0;
      else if ((fault_vec != 3'b000 || uncorrectable) && fault_cnt != 8'hFF)
        fault_cnt <= fault_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_tmr_down_counter.sv
// Bench for tmr_down_counter: directed scenarios plus randomized traffic
// against a behavioural TMR model.
module tb_tmr_down_counter;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, load, enable, clr_fault;
  logic [W-1:0] load_val, inject_mask;
  logic [2:0]   inject_sel;
  logic [W-1:0] q_out;
  logic         zero, done, uncorrectable;
  logic [2:0]   fault_vec, sticky_fault;
  logic [7:0]   fault_cnt;

  int n_chk = 0;
  int n_bad = 0;

  logic [W-1:0] m_rep [3];
  logic         m_done;
  logic [2:0]   m_sticky;
  int           m_cnt;

  tmr_down_counter #(.width(W)) dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .enable(enable),
    .clr_fault(clr_fault), .inject_sel(inject_sel), .inject_mask(inject_mask),
    .q_out(q_out), .zero(zero), .done(done), .fault_vec(fault_vec),
    .uncorrectable(uncorrectable), .sticky_fault(sticky_fault), .fault_cnt(fault_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Majority of three words: any two agreeing win, otherwise each bit by count.
  function automatic logic [W-1:0] m_vote();
    logic [W-1:0] r;
    int ones;
    if (m_rep[0] == m_rep[1] || m_rep[0] == m_rep[2]) return m_rep[0];
    if (m_rep[1] == m_rep[2]) return m_rep[1];
    for (int b = 0; b < W; b++) begin
      ones = 0;
      for (int i = 0; i < 3; i++) ones += int'(m_rep[i][b]);
      r[b] = (ones >= 2);
    end
    return r;
  endfunction

  function automatic logic [2:0] m_fv();
    logic [W-1:0] v = m_vote();
    logic [2:0] f;
    for (int i = 0; i < 3; i++) f[i] = (m_rep[i] != v);
    return f;
  endfunction

  function automatic logic m_unc();
    return (m_rep[0] != m_rep[1]) && (m_rep[0] != m_rep[2]) && (m_rep[1] != m_rep[2]);
  endfunction

  task automatic model_edge();
    logic [W-1:0] v = m_vote();
    logic [2:0]   f = m_fv();
    logic         u = m_unc();
    int           cnt;
    if (rst) begin
      for (int i = 0; i < 3; i++) m_rep[i] = '0;
      m_done = 0; m_sticky = 0; m_cnt = 0;
    end else begin
      // Every replica first takes the voted value, then advances.
      for (int i = 0; i < 3; i++) begin
        cnt = int'(v);
        if (load)        cnt = int'(load_val);
        else if (enable) cnt = (cnt > 0) ? cnt - 1 : 0;
        m_rep[i] = W'(cnt) ^ (inject_sel[i] ? inject_mask : W'(0));
      end
      m_done   = !load && enable && (v == 1);
      m_sticky = f | (clr_fault ? 3'b000 : m_sticky);
      if (clr_fault)                       m_cnt = 0;
      else if ((f != 0 || u) && m_cnt < 255) m_cnt = m_cnt + 1;
    end
  endtask

  task automatic check_all(input bit flt);
    logic [W-1:0] v = m_vote();
    chk("q_out", 32'(q_out), 32'(v));
    chk("zero", 32'(zero), 32'(v == 0));
    chk("done", 32'(done), 32'(m_done));
    chk("fault_vec", 32'(fault_vec), 32'(m_fv()));
    chk("uncorrectable", 32'(uncorrectable), 32'(m_unc()));
    if (flt) begin
      chk("sticky_fault", 32'(sticky_fault), 32'(m_sticky));
      chk("fault_cnt", 32'(fault_cnt), 32'(m_cnt));
    end
  endtask

  task automatic step(input bit flt = 1'b1);
    @(posedge clk);
    model_edge();
    #1;
    check_all(flt);
  endtask

  initial begin
    rst = 1; load = 0; enable = 0; clr_fault = 0;
    load_val = '0; inject_mask = '0; inject_sel = '0;
    for (int i = 0; i < 3; i++) m_rep[i] = 'x;
    m_done = 0; m_sticky = 0; m_cnt = 0;
    step(); step();
    chk("rst_q_out", 32'(q_out), 0);
    chk("rst_zero", 32'(zero), 1);
    chk("rst_cnt", 32'(fault_cnt), 0);
    rst = 0;
    step();
    chk("rst_fault_vec", 32'(fault_vec), 0);

    // Countdown from 5 with saturation at zero.
    load = 1; load_val = 8'd5; step();
    load = 0; enable = 1;
    for (int k = 0; k < 7; k++) begin
      step();
      chk("cd_q_out", 32'(q_out), (k < 4) ? 32'(4 - k) : 0);
      chk("cd_done", 32'(done), 32'(k == 4));
      chk("cd_zero", 32'(zero), 32'(k >= 4));
    end
    enable = 0;

    // Single-replica injection, then repair.
    load = 1; load_val = 8'h20; step();
    load = 0; inject_sel = 3'b010; inject_mask = 8'h01; step();
    inject_sel = 3'b000;
    chk("inj_q_out", 32'(q_out), 32'h20);
    chk("inj_fv", 32'(fault_vec), 32'b010);
    chk("inj_unc", 32'(uncorrectable), 0);
    step();
    chk("inj_fv_after", 32'(fault_vec), 0);
    chk("inj_sticky", 32'(sticky_fault), 32'b010);
    chk("inj_cnt", 32'(fault_cnt), 1);
    clr_fault = 1; step(); clr_fault = 0;

    // Three pairwise-different replicas, planted directly into the registers.
    load = 1; load_val = 8'h10; step(); load = 0;
    force dut.q_1 = 8'h11;
    force dut.q_2 = 8'h12;
    m_rep[0] = 8'h11; m_rep[1] = 8'h12; m_rep[2] = 8'h10;
    #1;
    chk("unc_q_out", 32'(q_out), 32'h10);
    chk("unc_flag", 32'(uncorrectable), 1);
    chk("unc_fv", 32'(fault_vec), 32'b011);
    release dut.q_1;
    release dut.q_2;
    clr_fault = 1;
    step(1'b0);
    chk("unc_resync_q", 32'(q_out), 32'h10);
    chk("unc_resync_fv", 32'(fault_vec), 0);
    m_sticky = 0; m_cnt = 0;
    step(); clr_fault = 0;

    // Load wins over enable.
    load = 1; load_val = 8'd3; step();
    load_val = 8'd9; enable = 1; step();
    chk("ld_en_q", 32'(q_out), 9);
    chk("ld_en_done", 32'(done), 0);
    load_val = 8'd0; step();
    chk("ld0_zero", 32'(zero), 1);
    chk("ld0_done", 32'(done), 0);
    load = 0; enable = 0;

    // Clear racing an active fault, then counter saturation.
    load = 1; load_val = 8'h30; step(); load = 0;
    inject_sel = 3'b001; inject_mask = 8'h01; step();
    clr_fault = 1; step(); clr_fault = 0;
    chk("clr_sticky", 32'(sticky_fault[0]), 1);
    chk("clr_cnt", 32'(fault_cnt), 0);
    for (int k = 0; k < 300; k++) step();
    chk("sat_cnt", 32'(fault_cnt), 255);
    inject_sel = 3'b000;

    // Reset mid-countdown with an injection pending.
    load = 1; load_val = 8'h40; step(); load = 0;
    rst = 1; enable = 1; inject_sel = 3'b101; inject_mask = 8'hFF; step();
    chk("rst_mid_q", 32'(q_out), 0);
    chk("rst_mid_zero", 32'(zero), 1);
    chk("rst_mid_done", 32'(done), 0);
    chk("rst_mid_sticky", 32'(sticky_fault), 0);
    chk("rst_mid_cnt", 32'(fault_cnt), 0);
    rst = 0; enable = 0; inject_sel = 3'b000;
    step();

    // Randomized traffic.
    for (int k = 0; k < 800; k++) begin
      rst       = ($urandom_range(63) == 0);
      load      = ($urandom_range(7) == 0);
      load_val  = ($urandom_range(1) == 0) ? W'($urandom_range(4)) : W'($urandom);
      enable    = ($urandom_range(3) != 0);
      clr_fault = ($urandom_range(15) == 0);
      inject_sel  = ($urandom_range(9) == 0) ? 3'($urandom) : 3'b000;
      inject_mask = W'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
